hazard_grid_encoder: RTL
========================

# hazard_grid_encoder

Streaming, parametrised successor to the combinational hazard encoder. Accepts one hazard bounding box per cycle over a valid/ready handshake, rasterises each box onto a GRID_ROWS × GRID_COLS occupancy grid, and OR-accumulates the boxes for one frame. At end of frame it presents the flat occupancy map over a second valid/ready handshake. It sits between the hazard detection front end and the spike encoding stage.

## Interface
Parameters:
- COORD_W, 11: coordinate width in pixels, unsigned.
- GRID_COLS, 8: grid columns.
- GRID_ROWS, 4: grid rows.
- CELL_W_LOG2, 7: cell width is 2^CELL_W_LOG2 pixels.
- CELL_H_LOG2, 8: cell height is 2^CELL_H_LOG2 pixels.
- MAX_HAZARDS, 16: boxes accepted per frame; later boxes are dropped.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  box present.
- in_ready  out  1  block accepts the box.
- in_last  in  1  box is the final one of its frame.
- in_top, in_left, in_bottom, in_right  in  COORD_W each  box edges, inclusive.
- map  out  GRID_ROWS*GRID_COLS  occupancy; bit index = row*GRID_COLS + col.
- map_valid  out  1  map holds a complete frame.
- map_ready  in  1  consumer takes the map.
- map_overflow  out  1  frame had more than MAX_HAZARDS boxes; valid with map_valid.
- map_malformed  out  1  frame had at least one box with left>right or top>bottom; valid with map_valid.

## Operation
- A box transfers on a cycle with in_valid && in_ready.
- Cell ranges: c0 = left>>CELL_W_LOG2, c1 = right>>CELL_W_LOG2, r0 = top>>CELL_H_LOG2, r1 = bottom>>CELL_H_LOG2. Any index ≥ GRID_COLS clips to GRID_COLS-1, and any index ≥ GRID_ROWS clips to GRID_ROWS-1.
- Every cell with c0≤col≤c1 and r0≤row≤r1 is set in the accumulator.
- A malformed box (left>right or top>bottom) sets no cells and sets the sticky malformed flag.
- A per-frame accept counter (width $clog2(MAX_HAZARDS+1)) counts transferred boxes. A box that arrives when the count already equals MAX_HAZARDS sets no cells and sets the sticky overflow flag. Its in_last is still honoured.
- Two-stage pipeline: S1 registers the clipped ranges, the malformed/drop flag, and last; S2 ORs the rectangle mask into the accumulator.
- FSM:
  - ACCUM: in_ready=1. When in_last transfers, go to DRAIN.
  - DRAIN: in_ready=0. Wait for the last box to retire from S2, then go to OUTPUT.
  - OUTPUT: in_ready=0, map_valid=1. map and flags are held stable. On map_ready, clear the accumulator, counter, and flags, then go to ACCUM.
- The accumulator does not clear between boxes, only on the output handshake.

## Timing
- Reset values: state ACCUM, in_ready=0 during the reset cycle and 1 in the first cycle after it, map=0, map_valid=0, map_overflow=0, map_malformed=0, counter=0. The S1 and S2 valids are cleared.
- Throughput: one box per cycle in ACCUM.
- Latency: if last transfers in cycle t, map_valid=1 in cycle t+2 with the full map, including boxes transferred at t-1 and t.
- in_ready falls in cycle t+1 and returns to 1 the cycle after the map handshake.
- map_valid && map_ready in cycle u: map_valid=0 and map=0 in cycle u+1.
- map_valid never drops without map_ready.
- If rst is asserted mid-frame or in OUTPUT, it takes effect the next edge. Partial frames and in-flight pipeline contents are discarded.
- in_valid held while in_ready=0 is ignored. No box is lost or double-counted.

## Configuration
- HAZARD_ENC_STATS_EN defined: adds two ports.
  - map_count, out, $clog2(MAX_HAZARDS+1): accepted boxes, excluding dropped ones. Well-formed boxes are counted; malformed boxes are counted too.
  - drop_count, out, 8: running saturating total of overflow drops since reset. It is not cleared per frame.
  - map_count is valid with map_valid and resets to 0.
- Undefined: these ports and their logic are absent. map, the flags, and timing are identical either way.

## Test plan
- Defaults. Frame of box (top 10, left 20, bottom 200, right 300) then box (300, 900, 900, 1230, last) → map = 0x80808007 at t+2, both flags 0.
- Single box (0, 0, 1023, 1023, last) → map = 0xFFFFFFFF. Box (2047, 2047, 2047, 2047, last) → clipped to bit 31, map = 0x80000000.
- Malformed (top 500, left 10, bottom 100, right 20, last) → map = 0, map_malformed = 1.
- 17 boxes (0, 0, 0, 0) with the 17th last, then next frame (0, 128, 0, 128, last) → frame 1: map = 0x1, overflow = 1. Frame 2: map = 0x2, overflow = 0.
- Hold map_ready=0 for 5 cycles in OUTPUT while in_valid=1 → map stable, in_ready=0, no box accepted. Release → accumulator cleared next cycle.
- Assert rst in the cycle after a mid-frame box → map_valid=0, map=0, in_ready=1 the following cycle. The next frame's map excludes the pre-reset boxes.

Source files
------------

// File: rtl/hazard_grid_encoder.sv
// hazard_grid_encoder: streaming hazard-box rasteriser.
// Accepts one bounding box per cycle and OR-accumulates it onto a
// GRID_ROWS x GRID_COLS occupancy map. At end of frame the map is
// presented over a valid/ready handshake.
// Optional statistics ports (map_count, drop_count) are enabled by
// defining HAZARD_ENC_STATS_EN.
module hazard_grid_encoder #(
   parameter int COORD_W     = 11,
   parameter int GRID_COLS   = 8,
   parameter int GRID_ROWS   = 4,
   parameter int CELL_W_LOG2 = 7,
   parameter int CELL_H_LOG2 = 8,
   parameter int MAX_HAZARDS = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_last,
   input  logic [COORD_W-1:0]               in_top,
   input  logic [COORD_W-1:0]               in_left,
   input  logic [COORD_W-1:0]               in_bottom,
   input  logic [COORD_W-1:0]               in_right,
   output logic [GRID_ROWS*GRID_COLS-1:0]   map,
   output logic                             map_valid,
   input  logic                             map_ready,
   output logic                             map_overflow,
`ifdef HAZARD_ENC_STATS_EN
   output logic [$clog2(MAX_HAZARDS+1)-1:0] map_count,
   output logic [7:0]                       drop_count,
`endif
   output logic                             map_malformed
);

   localparam int MAP_W  = GRID_ROWS * GRID_COLS;
   localparam int CNT_W  = $clog2(MAX_HAZARDS + 1);
   localparam int CIDX_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
   localparam int RIDX_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   // Pixel column to grid column, clipped to the last column.
   function automatic logic [CIDX_W-1:0] clip_col(input logic [COORD_W-1:0] px);
      logic [COORD_W-1:0] idx;
      idx = px >> CELL_W_LOG2;
      if (idx >= COORD_W'(GRID_COLS - 1)) begin
         return CIDX_W'(GRID_COLS - 1);
      end else begin
         return idx[CIDX_W-1:0];
      end
   endfunction

   // Pixel row to grid row, clipped to the last row.
   function automatic logic [RIDX_W-1:0] clip_row(input logic [COORD_W-1:0] px);
      logic [COORD_W-1:0] idx;
      idx = px >> CELL_H_LOG2;
      if (idx >= COORD_W'(GRID_ROWS - 1)) begin
         return RIDX_W'(GRID_ROWS - 1);
      end else begin
         return idx[RIDX_W-1:0];
      end
   endfunction

   state_t              state_q, state_d;
   logic                s1_valid_q, s1_valid_d;
   logic                s1_last_q, s1_last_d;
   logic                s1_drop_q, s1_drop_d;
   logic                s1_malformed_q, s1_malformed_d;
   logic [CIDX_W-1:0]   s1_c0_q, s1_c0_d, s1_c1_q, s1_c1_d;
   logic [RIDX_W-1:0]   s1_r0_q, s1_r0_d, s1_r1_q, s1_r1_d;
   logic [MAP_W-1:0]    acc_q, acc_d;
   logic                ovf_q, ovf_d;
   logic                mal_q, mal_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MAP_W-1:0]    mask_s;
   logic                in_fire_s, map_fire_s, drop_s, malformed_s;

   assign in_ready      = (state_q == ST_ACCUM) && !rst;
   assign map_valid     = (state_q == ST_OUTPUT);
   assign map           = acc_q;
   assign map_overflow  = ovf_q;
   assign map_malformed = mal_q;

   assign in_fire_s   = in_valid && in_ready;
   assign map_fire_s  = (state_q == ST_OUTPUT) && map_ready;
   assign drop_s      = (cnt_q == CNT_W'(MAX_HAZARDS));
   assign malformed_s = (in_left > in_right) || (in_top > in_bottom);

   // Rectangle mask of the box held in S1 (ranges are already clipped).
   for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
      for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
         assign mask_s[r*GRID_COLS + c] =
            (CIDX_W'(c) >= s1_c0_q) && (CIDX_W'(c) <= s1_c1_q) &&
            (RIDX_W'(r) >= s1_r0_q) && (RIDX_W'(r) <= s1_r1_q);
      end
   end

   // Frame FSM: accept boxes, let the last one retire, present the map.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: begin
            if (in_fire_s && in_last) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            if (s1_valid_q && s1_last_q) begin
               state_d = ST_OUTPUT;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_OUTPUT: begin
            if (map_ready) begin
               state_d = ST_ACCUM;
            end else begin
               state_d = ST_OUTPUT;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // S1: clip the incoming box and classify it as malformed or dropped.
   always_comb begin
      s1_valid_d     = in_fire_s;
      s1_last_d      = in_last;
      s1_drop_d      = drop_s;
      s1_malformed_d = malformed_s && !drop_s;
      s1_c0_d        = clip_col(in_left);
      s1_c1_d        = clip_col(in_right);
      s1_r0_d        = clip_row(in_top);
      s1_r1_d        = clip_row(in_bottom);
   end

   // S2: OR the mask into the accumulator, update sticky flags and the
   // accept counter; everything clears on the map handshake.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      mal_d = mal_q;
      cnt_d = cnt_q;
      if (map_fire_s) begin
         acc_d = '0;
         ovf_d = 1'b0;
         mal_d = 1'b0;
         cnt_d = '0;
      end else begin
         if (s1_valid_q && !s1_drop_q && !s1_malformed_q) begin
            acc_d = acc_q | mask_s;
         end else begin
            acc_d = acc_q;
         end
         if (s1_valid_q && s1_drop_q) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
         if (s1_valid_q && s1_malformed_q) begin
            mal_d = 1'b1;
         end else begin
            mal_d = mal_q;
         end
         if (in_fire_s && !drop_s) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // State, pipeline and accumulator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_ACCUM;
         s1_valid_q     <= 1'b0;
         s1_last_q      <= 1'b0;
         s1_drop_q      <= 1'b0;
         s1_malformed_q <= 1'b0;
         s1_c0_q        <= '0;
         s1_c1_q        <= '0;
         s1_r0_q        <= '0;
         s1_r1_q        <= '0;
         acc_q          <= '0;
         ovf_q          <= 1'b0;
         mal_q          <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         s1_valid_q     <= s1_valid_d;
         s1_last_q      <= s1_last_d;
         s1_drop_q      <= s1_drop_d;
         s1_malformed_q <= s1_malformed_d;
         s1_c0_q        <= s1_c0_d;
         s1_c1_q        <= s1_c1_d;
         s1_r0_q        <= s1_r0_d;
         s1_r1_q        <= s1_r1_d;
         acc_q          <= acc_d;
         ovf_q          <= ovf_d;
         mal_q          <= mal_d;
         cnt_q          <= cnt_d;
      end
   end

`ifdef HAZARD_ENC_STATS_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   assign map_count  = cnt_q;
   assign drop_count = drop_cnt_q;

   // Saturating count of dropped boxes since reset.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (in_fire_s && drop_s && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Drop counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end
`endif

endmodule
